// File: rtl/ins_queue_pkg.sv
// Shared definitions for the instruction queue and the decode path.
// Holds the reservation-station class encodings and the opcode/funct
// constants recognised by the head-entry decode.
package ins_queue_pkg;

  // Reservation-station class of an instruction. Nonest marks a type the
  // issue unit does not know how to place, so it must never be issued.
  typedef enum logic [2:0] {
    Addst  = 3'd1,
    Mulst  = 3'd2,
    MemLst = 3'd3,
    MemSst = 3'd4,
    Nonest = 3'd7
  } st_type_e;

  // Opcode field values (instruction bits 31:26)
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct field values (instruction bits 5:0)
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_MULT  = 6'h18;

endpackage

// File: rtl/ins_queue_decode.sv
// ins_decode: combinational map from {opcode, funct} to the
// reservation-station class. Shared with the dispatch path.
// Ports:
//   opcode   in  6  instruction bits 31:26
//   funct    in  6  instruction bits 5:0
//   st_type  out 3  station class (st_type_e encoding)
module ins_decode
  import ins_queue_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] st_type
);

  // Class lookup; unrecognised encodings fall through to Nonest
  always_comb begin
    st_type = Nonest;
    case (opcode)
      OP_RTYPE: begin
        if ((funct == FN_ADD) || (funct == FN_SUB)) begin
          st_type = Addst;
        end else if (funct == FN_MULT) begin
          st_type = Mulst;
        end else begin
          st_type = Nonest;
        end
      end
      OP_ADDI: st_type = Addst;
      OP_LW:   st_type = MemLst;
      OP_SW:   st_type = MemSst;
      default: st_type = Nonest;
    endcase
  end

endmodule

// File: rtl/ins_queue.sv
// ins_queue: instruction FIFO between fetch and the issue control unit.
// Stores {instruction, PC} pairs in a circular buffer, presents the head
// with its decoded station class, and pops the head when the issue unit
// can take it without a WAW hazard.
// Ports:
//   clk, nRST              clock, async active-low reset
//   flush                  synchronous clear (wins over push and pop)
//   in_valid/in_ins/in_pc  fetch push side; in_ready is back-pressure
//   issuable, WAW          issue-unit status for the current head
//   head_valid/ins/pc      head entry (zeroed when empty)
//   stType                 station class of the head (Nonest when empty)
//   issue_fire             head consumed this cycle
//   count                  occupancy, 0..DEPTH
module ins_queue
  import ins_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IW    = 32
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [IW-1:0]            in_ins,
  input  logic [IW-1:0]            in_pc,
  output logic                     in_ready,
  input  logic                     issuable,
  input  logic                     WAW,
  output logic                     head_valid,
  output logic [IW-1:0]            head_ins,
  output logic [IW-1:0]            head_pc,
  output logic [2:0]               stType,
  output logic                     issue_fire,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [IW-1:0] ins_mem_q [DEPTH];
  logic [IW-1:0] ins_mem_d [DEPTH];
  logic [IW-1:0] pc_mem_q  [DEPTH];
  logic [IW-1:0] pc_mem_d  [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          push_s;
  logic          pop_s;
  logic [2:0]    dec_st_s;

  // Head presentation and handshakes, all from registered state
  always_comb begin
    in_ready   = (count_q != FULL_CNT);
    head_valid = (count_q != '0);
    if (head_valid) begin
      head_ins = ins_mem_q[rd_ptr_q];
      head_pc  = pc_mem_q[rd_ptr_q];
      stType   = dec_st_s;
    end else begin
      head_ins = '0;
      head_pc  = '0;
      stType   = Nonest;
    end
    issue_fire = head_valid && issuable && !WAW;
    // A flush discards both the incoming word and any pop this cycle
    push_s     = in_valid && in_ready && !flush;
    pop_s      = issue_fire && !flush;
    count      = count_q;
  end

  ins_decode u_decode (
    .opcode  (head_ins[31:26]),
    .funct   (head_ins[5:0]),
    .st_type (dec_st_s)
  );

  // Next-state for storage, pointers and occupancy
  always_comb begin
    ins_mem_d = ins_mem_q;
    pc_mem_d  = pc_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        ins_mem_d[wr_ptr_q] = in_ins;
        pc_mem_d[wr_ptr_q]  = in_pc;
        wr_ptr_d            = wr_ptr_q + ONE_PTR;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + ONE_PTR;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      // Push and pop together leave occupancy unchanged
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        ins_mem_q[i] <= '0;
        pc_mem_q[i]  <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ins_mem_q <= ins_mem_d;
      pc_mem_q  <= pc_mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_ins_queue.sv
// Self-checking bench for ins_queue: a scoreboard queue mirrors the FIFO
// contents; expected head entries are compared whenever the head is shown.
module tb_ins_queue;
  import ins_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int IW    = 32;

  logic          clk;
  logic          nRST;
  logic          flush;
  logic          in_valid;
  logic [IW-1:0] in_ins;
  logic [IW-1:0] in_pc;
  logic          in_ready;
  logic          issuable;
  logic          WAW;
  logic          head_valid;
  logic [IW-1:0] head_ins;
  logic [IW-1:0] head_pc;
  logic [2:0]    stType;
  logic          issue_fire;
  logic [3:0]    count;

  ins_queue #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk        (clk),
    .nRST       (nRST),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ins     (in_ins),
    .in_pc      (in_pc),
    .in_ready   (in_ready),
    .issuable   (issuable),
    .WAW        (WAW),
    .head_valid (head_valid),
    .head_ins   (head_ins),
    .head_pc    (head_pc),
    .stType     (stType),
    .issue_fire (issue_fire),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [2:0]  st;
  } ent_t;

  ent_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_SUB  = 32'h00221822;
  localparam logic [31:0] I_ADDI = 32'h20410005;
  localparam logic [31:0] I_MULT = 32'h00220018;
  localparam logic [31:0] I_LW   = 32'h8C410004;
  localparam logic [31:0] I_SW   = 32'hAC410004;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_AND  = 32'h00221824;

  logic [31:0] ins_tab [8];
  initial begin
    ins_tab[0] = I_ADD;  ins_tab[1] = I_SUB;  ins_tab[2] = I_ADDI; ins_tab[3] = I_MULT;
    ins_tab[4] = I_LW;   ins_tab[5] = I_SW;   ins_tab[6] = I_BEQ;  ins_tab[7] = I_AND;
  end

  // Reference class of an instruction word
  function automatic logic [2:0] ref_st(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) return Addst;
    if (op == 6'h08) return Addst;
    if (op == 6'h00 && fn == 6'h18) return Mulst;
    if (op == 6'h23) return MemLst;
    if (op == 6'h2B) return MemSst;
    return Nonest;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, check combinational head at negedge,
  // update scoreboard at posedge, then check registered count.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic iss, input logic waw, input logic fl);
    logic exp_fire;
    logic push_ok;
    ent_t e;
    in_valid = v; in_ins = ins; in_pc = pc; issuable = iss; WAW = waw; flush = fl;
    @(negedge clk);
    exp_fire = (sb.size() != 0) && iss && !waw;
    check_val("in_ready",   32'(in_ready),   32'(sb.size() != DEPTH));
    check_val("head_valid", 32'(head_valid), 32'(sb.size() != 0));
    check_val("issue_fire", 32'(issue_fire), 32'(exp_fire));
    if (sb.size() != 0) begin
      check_val("head_pc",  head_pc,       sb[0].pc);
      check_val("head_ins", head_ins,      sb[0].ins);
      check_val("stType",   32'(stType),   32'(sb[0].st));
    end else begin
      check_val("head_ins_empty", head_ins,     32'h0);
      check_val("head_pc_empty",  head_pc,      32'h0);
      check_val("stType_empty",   32'(stType),  32'(Nonest));
    end
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      push_ok = v && (sb.size() != DEPTH);
      if (exp_fire) void'(sb.pop_front());
      if (push_ok) begin
        e.ins = ins; e.pc = pc; e.st = ref_st(ins);
        sb.push_back(e);
      end
    end
    #1;
    check_val("count", 32'(count), 32'(sb.size()));
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    cyc(1'b1, ins, pc, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ins = '0; in_pc = '0;
    issuable = 1'b1; WAW = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with issuable held high
    check_val("rst_count",      32'(count),      32'd0);
    check_val("rst_in_ready",   32'(in_ready),   32'd1);
    check_val("rst_head_valid", 32'(head_valid), 32'd0);
    check_val("rst_head_ins",   head_ins,        32'h0);
    check_val("rst_stType",     32'(stType),     32'(Nonest));
    check_val("rst_issue_fire", 32'(issue_fire), 32'd0);
    nRST = 1'b1;

    // Reset then push an add at PC 0x4
    push(I_ADD, 32'h4);
    idle();
    check_val("first_st", 32'(stType), 32'(Addst));
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Fill to DEPTH with the issue side stalled, try a 9th push, then drain
    for (int i = 0; i < DEPTH; i++) push(ins_tab[i], 32'h100 + 32'(4 * i));
    cyc(1'b1, I_ADD, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    check_val("full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Hazard gating on a lw head
    push(I_LW, 32'h200);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    check_val("waw_stType", 32'(stType), 32'(MemLst));
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Simultaneous push and pop at count 1
    push(I_MULT, 32'h300);
    cyc(1'b1, I_SW, 32'h304, 1'b1, 1'b0, 1'b0);
    check_val("pp_stType", 32'(stType), 32'(MemSst));
    idle();
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush priority with count 5
    for (int i = 0; i < 5; i++) push(ins_tab[i], 32'h400 + 32'(4 * i));
    cyc(1'b1, I_ADD, 32'h500, 1'b1, 1'b0, 1'b1);
    check_val("flush_head_ins", head_ins, 32'h0);
    idle();

    // Asynchronous reset mid-cycle with count 3
    for (int i = 0; i < 3; i++) push(ins_tab[i], 32'h600 + 32'(4 * i));
    #1 nRST = 1'b0;
    #1;
    sb.delete();
    check_val("arst_count",    32'(count),    32'd0);
    check_val("arst_in_ready", 32'(in_ready), 32'd1);
    check_val("arst_stType",   32'(stType),   32'(Nonest));
    #1 nRST = 1'b1;
    idle();

    // Mixed traffic
    for (int n = 0; n < 60; n++) begin
      cyc(1'($urandom_range(0, 1)), ins_tab[$urandom_range(0, 5)], 32'h1000 + 32'(4 * n),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 19) == 0));
    end
    // Drain, bounded
    for (int n = 0; n < DEPTH + 2; n++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
